// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    // Controller states: waiting, iterating, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must be able to represent 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mul_abs
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // Most negative value maps onto itself, which read as unsigned is its true magnitude.
    assign dout = neg ? -din : din;

endmodule

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier, signed or unsigned, full 2*WIDTH product plus flags.
// Latency: done asserted in the WIDTH+1'th cycle after the accepting edge; one result per WIDTH+1 cycles back-to-back.
// Backpressure: start is only looked at in IDLE/DONE; while busy it is ignored, no queueing.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] hi,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;     // |a|, held for the whole run
    logic [2*WIDTH-1:0]   acc;       // high half: partial product; low half: remaining multiplier bits
    logic                 neg_q;     // result needs negation
    logic                 sgn_q;     // operation was signed (selects overflow rule)

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   prod;
    logic                 prod_n;
    logic                 prod_z;
    logic                 prod_v;

    mul_abs #(.WIDTH(WIDTH)) u_abs_a (
        .din  (a),
        .neg  (is_signed & a[WIDTH-1]),
        .dout (a_mag)
    );

    mul_abs #(.WIDTH(WIDTH)) u_abs_b (
        .din  (b),
        .neg  (is_signed & b[WIDTH-1]),
        .dout (b_mag)
    );

    // Final iteration's accumulator goes through the sign fix-up before being registered.
    mul_abs #(.WIDTH(2*WIDTH)) u_fix (
        .din  (acc_nxt),
        .neg  (neg_q),
        .dout (prod)
    );

    // One shift-add step: add multiplicand if the current multiplier bit is set, then shift right.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // Flags of the candidate result; overflow means the product does not fit in WIDTH bits.
    always_comb begin
        prod_n = prod[WIDTH-1];
        prod_z = (prod[WIDTH-1:0] == '0);
        prod_v = 1'b0;
        if (sgn_q)
            prod_v = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        else
            prod_v = (prod[2*WIDTH-1:WIDTH] != '0);
    end

    // Carry has no meaning for a multiply.
    assign c = 1'b0;

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            sgn_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
            hi    <= '0;
            n     <= 1'b0;
            z     <= 1'b0;
            v     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        mcand <= a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_q <= is_signed;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        r     <= prod[WIDTH-1:0];
                        hi    <= prod[2*WIDTH-1:WIDTH];
                        n     <= prod_n;
                        z     <= prod_z;
                        v     <= prod_v;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector bench for mul_seq at WIDTH=32.
// Latency: expects done in the 33rd sampled cycle after the accepting edge.
// Backpressure: exercises start during RUN, held start, and reset mid-run.
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] hi;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    mul_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .r         (r),
        .hi        (hi),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation; optionally pulse start with junk operands at RUN cycle
    // pulse_at, or raise rst at RUN cycle rst_at (then return immediately).
    task automatic run_op(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                          input int pulse_at, input int rst_at,
                          output int dcyc, output int bcnt);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a = aa; b = bb;
        @(posedge clk);
        dcyc = 0;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == pulse_at) begin
                start = 1'b1; is_signed = ~sgn; a = 32'h9; b = 32'h9;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                break;
            end
            if (busy) bcnt++;
            if (done) begin
                dcyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int dcyc, input int bcnt,
                                input logic [31:0] er, input logic [31:0] ehi,
                                input logic en, input logic ez, input logic ev);
        check({tag, " done_cycle"}, 64'(dcyc), 64'd33);
        check({tag, " busy_cycles"}, 64'(bcnt), 64'd32);
        check({tag, " r"}, {32'h0, r}, {32'h0, er});
        check({tag, " hi"}, {32'h0, hi}, {32'h0, ehi});
        check({tag, " nzcv"}, {60'h0, n, z, c, v}, {60'h0, en, ez, 1'b0, ev});
    endtask

    initial begin
        int dc;
        int bc;
        int d1;
        int d2;
        int seen;

        // Reset held with start asserted: nothing must launch.
        rst = 1'b1; start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        repeat (3) @(negedge clk);
        check("reset outputs", {r, hi}, 64'h0);
        check("reset flags", {58'h0, n, z, c, v, busy, done}, 64'h0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle after reset", {62'h0, busy, done}, 64'h0);

        // Unsigned 3*5.
        run_op(1'b0, 32'd3, 32'd5, 0, 0, dc, bc);
        check_result("u3x5", dc, bc, 32'h0000000F, 32'h0, 1'b0, 1'b0, 1'b0);

        // Signed -2*3.
        run_op(1'b1, 32'hFFFFFFFE, 32'h00000003, 0, 0, dc, bc);
        check_result("s-2x3", dc, bc, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

        // Unsigned 2^16 * 2^16: low word zero, overflow into hi.
        run_op(1'b0, 32'h00010000, 32'h00010000, 0, 0, dc, bc);
        check_result("u2^32", dc, bc, 32'h0, 32'h00000001, 1'b0, 1'b1, 1'b1);

        // Signed most-negative * -1.
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, dc, bc);
        check_result("s-min", dc, bc, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b1);

        // Zero operand: full latency, zero result.
        run_op(1'b1, 32'h0, 32'hFFFFFFFF, 0, 0, dc, bc);
        check_result("zero", dc, bc, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Unsigned max*max: 0xFFFFFFFE_00000001.
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, dc, bc);
        check_result("umax", dc, bc, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);

        // Start pulsed in RUN cycle 10 is ignored.
        run_op(1'b0, 32'd7, 32'd6, 10, 0, dc, bc);
        check_result("ignore_start", dc, bc, 32'd42, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("no relaunch", {62'h0, busy, done}, 64'h0);

        // Reset in RUN cycle 20 aborts and clears outputs immediately.
        run_op(1'b0, 32'hFFFF, 32'hFFFF, 0, 20, dc, bc);
        check("abort outputs", {r, hi}, 64'h0);
        check("abort flags", {58'h0, n, z, c, v, busy, done}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("no done after abort", 64'(seen), 64'd0);

        // Start held high across two results.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    check("b2b first r", {32'h0, r}, 64'd15);
                    a = 32'd7; b = 32'd11;
                end else begin
                    d2 = k;
                    check("b2b second r", {32'h0, r}, 64'd77);
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b spacing", 64'(d2 - d1), 64'd33);
        check("b2b first seen", 64'(d1 != 0), 64'd1);
        @(negedge clk);
        check("b2b idle", {62'h0, busy, done}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
